ocspm_arb: RTL

- Parametrised next-generation on-chip scratchpad: a single-port synchronous RAM shared by one Wishbone classic slave port and NUM_DMA cDMA channels.
- Adds to the previous scratchpad:
  - configurable data width with byte-lane selects
  - multiple DMA channels with round-robin arbitration
  - explicit per-channel grant/valid handshake
  - WB wait-states while DMA holds the RAM
- Sits on the system Wishbone bus as a data/scratch memory and behind the cDMA engine.

---
 rtl/ocspm_arb.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ocspm_arb.sv
// ocspm_arb: single-port scratchpad shared by one Wishbone classic slave and
// NUM_DMA cDMA channels. Round-robin arbitration, one RAM access per cycle.
// Optional per-lane even parity storage/check enabled by macro OCSPM_PARITY_EN.
module ocspm_arb #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SEL_WIDTH  = DATA_WIDTH / 8,
  parameter int unsigned SPM_DEPTH  = 1024,
  parameter int unsigned SPM_AWID   = $clog2(SPM_DEPTH),
  parameter int unsigned NUM_DMA    = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [SPM_AWID-1:0]             WB_ADRi,
  input  logic [DATA_WIDTH-1:0]           WB_DATi,
  output logic [DATA_WIDTH-1:0]           WB_DATo,
  input  logic [SEL_WIDTH-1:0]            WB_SELi,
  input  logic                            WB_WEi,
  input  logic                            WB_CYCi,
  input  logic                            WB_STBi,
  output logic                            WB_ACKo,
  input  logic [NUM_DMA-1:0]              dma_req,
  input  logic [NUM_DMA-1:0]              dma_we,
  input  logic [NUM_DMA*SPM_AWID-1:0]     dma_addr,
  input  logic [NUM_DMA*SEL_WIDTH-1:0]    dma_sel,
  input  logic [NUM_DMA*DATA_WIDTH-1:0]   dma_dat_i,
  output logic [NUM_DMA-1:0]              dma_gnt,
  output logic [DATA_WIDTH-1:0]           dma_dat_o,
  output logic [NUM_DMA-1:0]              dma_vld,
  output logic                            par_err
);

  // Requester 0 is WB, requester i+1 is DMA channel i.
  localparam int unsigned NREQ  = NUM_DMA + 1;
  localparam int unsigned PTR_W = $clog2(NREQ);

  logic [DATA_WIDTH-1:0] r_mem [SPM_DEPTH];

  logic                  r_ack;
  logic [PTR_W-1:0]      r_ptr;
  logic [DATA_WIDTH-1:0] r_wb_dat;
  logic [DATA_WIDTH-1:0] r_dma_dat;
  logic [NUM_DMA-1:0]    r_vld;

  logic [NREQ-1:0]       w_pend;
  logic [PTR_W-1:0]      w_idx;
  logic [PTR_W-1:0]      w_win;
  logic                  w_gnt_vld;
  logic                  w_wb_gnt;
  logic [SPM_AWID-1:0]   w_addr;
  logic [DATA_WIDTH-1:0] w_wdat;
  logic [SEL_WIDTH-1:0]  w_sel;
  logic                  w_we;
  logic                  w_in_rng;
  logic [DATA_WIDTH-1:0] w_rdat;

  // Nothing is pending while reset is held, so a reset-cycle access never commits.
  assign w_pend = rst ? '0 : {dma_req, WB_CYCi & WB_STBi & ~r_ack};

  // Round-robin search starting one past the last winner.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_win     = '0;
    w_idx     = '0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      w_idx = PTR_W'((int'(r_ptr) + k) % int'(NREQ));
      if (!w_gnt_vld && w_pend[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_win     = w_idx;
      end
    end
  end

  assign w_wb_gnt = w_gnt_vld && (w_win == '0);

  // One-hot DMA grant decode.
  always_comb begin
    dma_gnt = '0;
    for (int i = 0; i < int'(NUM_DMA); i++) begin
      dma_gnt[i] = w_gnt_vld && (w_win == PTR_W'(i + 1));
    end
  end

  // Route the winning requester onto the RAM port.
  always_comb begin
    w_addr = WB_ADRi;
    w_wdat = WB_DATi;
    w_sel  = WB_SELi;
    w_we   = WB_WEi;
    for (int i = 0; i < int'(NUM_DMA); i++) begin
      if (dma_gnt[i]) begin
        w_addr = dma_addr[i*SPM_AWID +: SPM_AWID];
        w_wdat = dma_dat_i[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel  = dma_sel[i*SEL_WIDTH +: SEL_WIDTH];
        w_we   = dma_we[i];
      end
    end
  end

  // Out-of-range words read as zero and are never written.
  assign w_in_rng = (32'(w_addr) < SPM_DEPTH);
  assign w_rdat   = w_in_rng ? r_mem[w_addr] : '0;

  // Byte-lane RAM write; read-first because the read register samples old contents.
  always_ff @(posedge clk) begin
    if (!rst && w_gnt_vld && w_we && w_in_rng) begin
      for (int b = 0; b < int'(SEL_WIDTH); b++) begin
        if (w_sel[b]) begin
          r_mem[w_addr][b*8 +: 8] <= w_wdat[b*8 +: 8];
        end
      end
    end
  end

  // Ack, valid, read-data and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack     <= 1'b0;
      r_vld     <= '0;
      r_wb_dat  <= '0;
      r_dma_dat <= '0;
      r_ptr     <= PTR_W'(NUM_DMA);
    end else begin
      r_ack <= w_wb_gnt;
      r_vld <= dma_gnt;
      if (w_gnt_vld) begin
        r_ptr <= w_win;
      end
      if (w_wb_gnt && !w_we) begin
        r_wb_dat <= w_rdat;
      end
      if (|dma_gnt) begin
        r_dma_dat <= w_rdat;
      end
    end
  end

  assign WB_ACKo   = r_ack & WB_CYCi;
  assign WB_DATo   = r_wb_dat;
  assign dma_dat_o = r_dma_dat;
  assign dma_vld   = r_vld;

`ifdef OCSPM_PARITY_EN
  logic [SEL_WIDTH-1:0] r_par [SPM_DEPTH];
  logic                 r_perr;
  logic                 w_par_bad;

  // Even parity bit stored alongside each written lane.
  always_ff @(posedge clk) begin
    if (!rst && w_gnt_vld && w_we && w_in_rng) begin
      for (int b = 0; b < int'(SEL_WIDTH); b++) begin
        if (w_sel[b]) begin
          r_par[w_addr][b] <= ^w_wdat[b*8 +: 8];
        end
      end
    end
  end

  // Compare stored parity with the word being read; out-of-range never flags.
  always_comb begin
    w_par_bad = 1'b0;
    if (w_in_rng) begin
      for (int b = 0; b < int'(SEL_WIDTH); b++) begin
        if (r_par[w_addr][b] != ^w_rdat[b*8 +: 8]) begin
          w_par_bad = 1'b1;
        end
      end
    end
  end

  // Error pulse aligned with the ack/valid of the read.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perr <= 1'b0;
    end else begin
      r_perr <= w_gnt_vld && !w_we && w_par_bad;
    end
  end

  assign par_err = r_perr;
`else
  assign par_err = 1'b0;
`endif

endmodule
